// File: rtl/change_dispenser_if.sv
// Payout command/status and coin-hopper handshake bundle for change_dispenser.
// COIN_TALLY_EN adds per-denomination coin tallies to the status side.
interface change_dispenser_if;
  logic       start;
  logic [9:0] amount;
  logic       abort;
  logic       coin_ack;
  logic       coin_req;
  logic [1:0] coin_type;
  logic [9:0] remaining;
  logic       busy;
  logic       done;
  logic       short;
  logic       fault;
`ifdef COIN_TALLY_EN
  logic [7:0] tally_5;
  logic [7:0] tally_1;
  logic [7:0] tally_05;
`endif

  modport master (
    output start, amount, abort, coin_ack,
`ifdef COIN_TALLY_EN
    input  tally_5, tally_1, tally_05,
`endif
    input  coin_req, coin_type, remaining, busy, done, short, fault
  );

  modport slave (
    input  start, amount, abort, coin_ack,
`ifdef COIN_TALLY_EN
    output tally_5, tally_1, tally_05,
`endif
    output coin_req, coin_type, remaining, busy, done, short, fault
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays an amount out as largest-first coin requests over a four-phase req/ack hopper handshake;
// coin_req rises 2 edges after start, hopper stalls are unbounded except in REQ (TIMEOUT -> FAULT). Option: COIN_TALLY_EN.
module change_dispenser #(
  parameter int TIMEOUT    = 1000,
  parameter int MAX_AMOUNT = 999
) (
  input  logic               clk,
  input  logic               rst_n,
  change_dispenser_if.slave  bus
);

  localparam int         TW    = $clog2(TIMEOUT);
  localparam logic [9:0] MAX_A = 10'(MAX_AMOUNT);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    REQ,
    WAIT_REL,
    DONE,
    FAULT
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          coin_req_q;
  logic [1:0]    coin_type_q;
  logic [9:0]    remaining_q;
  logic          busy_q;
  logic          done_q;
  logic          short_q;
  logic          short_flag_q;
  logic          fault_q;
`ifdef COIN_TALLY_EN
  logic [7:0]    tally_5_q;
  logic [7:0]    tally_1_q;
  logic [7:0]    tally_05_q;
`endif

  logic [9:0] clamp_d;
  logic [9:0] residue_d;
  logic [9:0] start_rem_d;
  logic [9:0] coin_val_d;

  // The residue below one 0.5-yuan coin can never be paid, so it is dropped up front.
  always_comb begin
    clamp_d     = (bus.amount > MAX_A) ? MAX_A : bus.amount;
    residue_d   = clamp_d % 10'd5;
    start_rem_d = clamp_d - residue_d;
    case (coin_type_q)
      2'd2:    coin_val_d = 10'd50;
      2'd1:    coin_val_d = 10'd10;
      default: coin_val_d = 10'd5;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      coin_req_q   <= 1'b0;
      coin_type_q  <= 2'd0;
      remaining_q  <= 10'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      short_flag_q <= 1'b0;
      fault_q      <= 1'b0;
`ifdef COIN_TALLY_EN
      tally_5_q    <= 8'd0;
      tally_1_q    <= 8'd0;
      tally_05_q   <= 8'd0;
`endif
    end else if (bus.abort) begin
      // remaining_q and the tallies are intentionally left untouched
      state_q    <= IDLE;
      timer_q    <= '0;
      coin_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          short_q <= 1'b0;
          if (bus.start) begin
            remaining_q  <= start_rem_d;
            short_flag_q <= (residue_d != 10'd0);
            busy_q       <= 1'b1;
            state_q      <= SELECT;
`ifdef COIN_TALLY_EN
            tally_5_q    <= 8'd0;
            tally_1_q    <= 8'd0;
            tally_05_q   <= 8'd0;
`endif
          end
        end
        SELECT: begin
          timer_q <= '0;
          if (remaining_q >= 10'd50) begin
            coin_type_q <= 2'd2;
            coin_req_q  <= 1'b1;
            state_q     <= REQ;
          end else if (remaining_q >= 10'd10) begin
            coin_type_q <= 2'd1;
            coin_req_q  <= 1'b1;
            state_q     <= REQ;
          end else if (remaining_q >= 10'd5) begin
            coin_type_q <= 2'd0;
            coin_req_q  <= 1'b1;
            state_q     <= REQ;
          end else begin
            done_q  <= 1'b1;
            short_q <= short_flag_q;
            state_q <= DONE;
          end
        end
        REQ: begin
          if (bus.coin_ack) begin
            remaining_q <= remaining_q - coin_val_d;
            coin_req_q  <= 1'b0;
            state_q     <= WAIT_REL;
`ifdef COIN_TALLY_EN
            case (coin_type_q)
              2'd2:    if (tally_5_q  != 8'hFF) tally_5_q  <= tally_5_q  + 8'd1;
              2'd1:    if (tally_1_q  != 8'hFF) tally_1_q  <= tally_1_q  + 8'd1;
              default: if (tally_05_q != 8'hFF) tally_05_q <= tally_05_q + 8'd1;
            endcase
`endif
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            coin_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= FAULT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!bus.coin_ack) state_q <= SELECT;
        end
        DONE: begin
          done_q  <= 1'b0;
          short_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        FAULT: begin
          fault_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          coin_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin_req  = coin_req_q;
  assign bus.coin_type = coin_type_q;
  assign bus.remaining = remaining_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.short     = short_q;
  assign bus.fault     = fault_q;
`ifdef COIN_TALLY_EN
  assign bus.tally_5   = tally_5_q;
  assign bus.tally_1   = tally_1_q;
  assign bus.tally_05  = tally_05_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payout amounts plus hand sequences for timeout, abort and reset.
module tb_change_dispenser;

  localparam int TOUT = 20;

  logic clk;
  logic rst_n;
  logic hop_en;
  logic hop_ack;
  logic man_ack;

  change_dispenser_if bus();

  assign bus.coin_ack = hop_en ? hop_ack : man_ack;

  change_dispenser #(.TIMEOUT(TOUT), .MAX_AMOUNT(999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int hop_types[$];
  int hop_rem[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hopper model: ack one cycle after seeing req, release one cycle after req drops.
  initial begin
    int cnt;
    int ty;
    hop_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (hop_en && bus.coin_req) begin
        ty = int'(bus.coin_type);
        hop_types.push_back(ty);
        @(negedge clk);
        check("coin_type_stable", bus.coin_type, ty);
        hop_ack = 1'b1;
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (bus.coin_req && cnt < 50);
        hop_rem.push_back(int'(bus.remaining));
        @(negedge clk);
        hop_ack = 1'b0;
      end
    end
  end

  task automatic run_payout(input logic [9:0] a, output int ndone, output int done_at,
                            output int nbusy, output logic sh, output logic tmo);
    ndone = 0; done_at = -1; nbusy = 0; sh = 1'b0; tmo = 1'b1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.amount = a;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.amount = 10'($urandom);
    for (int i = 1; i <= 3000; i++) begin
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        done_at = i;
        sh = bus.short;
      end
      if (!bus.busy) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [9:0] amt;
    int         n2;
    int         n1;
    int         n05;
    logic       sh;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ndone, done_at, nbusy, base, c2, c1, c05, cnt;
    logic sh, tmo;
    int exp_t[5];
    int exp_r[5];

    vecs[0] = '{10'd85,   1, 3, 1, 1'b0};
    vecs[1] = '{10'd1023, 19, 4, 1, 1'b1};
    vecs[2] = '{10'd0,    0, 0, 0, 1'b0};
    vecs[3] = '{10'd7,    0, 0, 1, 1'b1};
    vecs[4] = '{10'd4,    0, 0, 0, 1'b1};
    vecs[5] = '{10'd65,   1, 1, 1, 1'b0};
    vecs[6] = '{10'd999,  19, 4, 1, 1'b1};
    vecs[7] = '{10'd123,  2, 2, 0, 1'b1};
    vecs[8] = '{10'd85,   1, 3, 1, 1'b0};
    exp_t = '{2, 1, 1, 1, 0};
    exp_r = '{35, 25, 15, 5, 0};

    rst_n = 1'b0; hop_en = 1'b1; man_ack = 1'b0;
    bus.start = 1'b0; bus.amount = 10'd0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coin_req", bus.coin_req, 0);
    check("rst_coin_type", bus.coin_type, 0);
    check("rst_remaining", bus.remaining, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_short", bus.short, 0);
    check("rst_fault", bus.fault, 0);
`ifdef COIN_TALLY_EN
    check("rst_tally", {bus.tally_5, bus.tally_1, bus.tally_05}, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      base = hop_types.size();
      run_payout(vecs[k].amt, ndone, done_at, nbusy, sh, tmo);
      c2 = 0; c1 = 0; c05 = 0;
      for (int j = base; j < hop_types.size(); j++) begin
        if (hop_types[j] == 2) c2++;
        else if (hop_types[j] == 1) c1++;
        else c05++;
      end
      check($sformatf("v%0d_timeout", k), tmo, 0);
      check($sformatf("v%0d_n_type2", k), c2, vecs[k].n2);
      check($sformatf("v%0d_n_type1", k), c1, vecs[k].n1);
      check($sformatf("v%0d_n_type0", k), c05, vecs[k].n05);
      check($sformatf("v%0d_done_pulses", k), ndone, 1);
      check($sformatf("v%0d_short", k), sh, vecs[k].sh);
      check($sformatf("v%0d_remaining", k), bus.remaining, 0);
      check($sformatf("v%0d_fault", k), bus.fault, 0);
`ifdef COIN_TALLY_EN
      check($sformatf("v%0d_tally_5", k), bus.tally_5, vecs[k].n2);
      check($sformatf("v%0d_tally_1", k), bus.tally_1, vecs[k].n1);
      check($sformatf("v%0d_tally_05", k), bus.tally_05, vecs[k].n05);
`endif
      repeat (2) @(negedge clk);
    end

    // Exact coin order and remaining trace for 85
    base = hop_types.size();
    run_payout(10'd85, ndone, done_at, nbusy, sh, tmo);
    check("seq85_len", hop_types.size() - base, 5);
    for (int j = 0; j < 5; j++) begin
      if (base + j < hop_types.size()) begin
        check($sformatf("seq85_type%0d", j), hop_types[base + j], exp_t[j]);
        check($sformatf("seq85_rem%0d", j), hop_rem[base + j], exp_r[j]);
      end
    end

    // Zero amount: done after two edges, busy exactly two cycles
    base = hop_types.size();
    run_payout(10'd0, ndone, done_at, nbusy, sh, tmo);
    check("zero_done_at", done_at, 2);
    check("zero_busy_cycles", nbusy, 2);
    check("zero_no_coin", hop_types.size() - base, 0);

    // Timeout with the hopper silent, then abort
    hop_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.amount = 10'd60;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && !bus.fault; i++) begin
      if (bus.coin_req) cnt++;
      @(negedge clk);
    end
    check("to_req_cycles", cnt, TOUT);
    check("to_fault", bus.fault, 1);
    check("to_coin_req", bus.coin_req, 0);
    check("to_remaining", bus.remaining, 60);
    repeat (5) @(negedge clk);
    check("to_fault_held", bus.fault, 1);
    check("to_busy_held", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_fault", bus.fault, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_remaining", bus.remaining, 60);
    @(negedge clk);

    // Start ignored in REQ, asynchronous reset while waiting for release
    bus.start = 1'b1; bus.amount = 10'd60;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.coin_req; i++) @(negedge clk);
    check("rs_req", bus.coin_req, 1);
    bus.start = 1'b1; bus.amount = 10'd10;
    @(negedge clk);
    bus.start = 1'b0;
    man_ack = 1'b1;
    for (int i = 0; i < 20 && bus.coin_req; i++) @(negedge clk);
    check("rs_remaining", bus.remaining, 10);
    check("rs_coin_type", bus.coin_type, 2);
    @(negedge clk);
    check("rs_busy_wait_rel", bus.busy, 1);
    check("rs_no_req_wait_rel", bus.coin_req, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_remaining", bus.remaining, 0);
    check("arst_coin_type", bus.coin_type, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_flags", {bus.coin_req, bus.done, bus.short, bus.fault}, 0);
    @(negedge clk);
    man_ack = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
